// File: rtl/lhp_bht_pkg.sv
// -----------------------------------------------------------------------------
// lhp_bht_pkg
// Shared types for the two-level local-history branch predictor:
//   bht_update_t     - resolved branch (valid, pc, taken) from the backend
//   bht_prediction_t - per-slot prediction (valid, taken) to the frontend
//   flush_state_e    - flush sweep FSM states
//   max_u            - helper for derived localparams
// -----------------------------------------------------------------------------
package lhp_bht_pkg;

  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lhp_bht_if.sv
// -----------------------------------------------------------------------------
// lhp_bht_if
// Frontend <-> predictor bus.
//   vpc            - fetch PC driving the combinational prediction
//   bht_update     - resolved branch from the backend
//   bht_prediction - one valid/taken pair per fetch slot
// master: frontend side; slave: predictor side.
// -----------------------------------------------------------------------------
interface lhp_bht_if
  import lhp_bht_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = 2
) ();

  logic [VLEN-1:0]                             vpc;
  bht_update_t                                 bht_update;
  bht_prediction_t [INSTR_PER_FETCH-1:0]       bht_prediction;

  modport master (
    output vpc,
    output bht_update,
    input  bht_prediction
  );

  modport slave (
    input  vpc,
    input  bht_update,
    output bht_prediction
  );

endinterface

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Combinational saturating up/down counter update, shared by predictors.
//   ctr_i   - current counter value
//   taken_i - 1: increment toward all-ones, 0: decrement toward zero
//   ctr_o   - updated counter value
// -----------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                taken_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/lhp_bht.sv
// -----------------------------------------------------------------------------
// lhp_bht
// Two-level local-history branch predictor. A per-slot local history table
// (LHT) of shift-register histories indexes a per-slot pattern history table
// (PHT) of saturating counters. Updates go through one registered
// read-modify-write stage; flush is a multi-cycle sweep.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_bp_i     - start / restart the flush sweep
//   debug_mode_i   - suppresses updates when DEBUG_EN
//   bp             - vpc in, resolved update in, per-slot predictions out
//   flush_busy_o   - sweep in progress (predictions forced invalid)
// -----------------------------------------------------------------------------
module lhp_bht
  import lhp_bht_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          RVC             = 1'b1,
  parameter bit          DEBUG_EN        = 1'b1,
  parameter int unsigned HIST_BITS       = 8,
  parameter int unsigned CTR_BITS        = 2,
  parameter bit          HASH_PC         = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_bp_i,
  input  logic     debug_mode_i,
  lhp_bht_if.slave bp,
  output logic     flush_busy_o
);

  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROWS          = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_BITS      = $clog2(ROWS);
  localparam int unsigned SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
  localparam int unsigned PHT_DEPTH     = 1 << HIST_BITS;
  localparam int unsigned SWEEP_LEN     = max_u(ROWS, PHT_DEPTH);
  localparam int unsigned CNT_W         = $clog2(SWEEP_LEN);

  typedef logic [ROW_BITS-1:0]  row_t;
  typedef logic [SLOT_W-1:0]    slot_t;
  typedef logic [HIST_BITS-1:0] hist_t;
  typedef logic [CTR_BITS-1:0]  ctr_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  localparam ctr_t CTR_INIT   = ctr_t'(1 << (CTR_BITS - 1));
  localparam cnt_t SWEEP_LAST = cnt_t'(SWEEP_LEN - 1);

  function automatic row_t pc_row(input logic [VLEN-1:0] pc);
    return row_t'(pc >> (ROW_ADDR_BITS + OFFSET));
  endfunction

  // Without compressed instructions every branch sits in slot 0.
  function automatic slot_t pc_slot(input logic [VLEN-1:0] pc);
    if (!RVC || ROW_ADDR_BITS == 0) return '0;
    return slot_t'(pc >> OFFSET);
  endfunction

  function automatic hist_t pht_idx(input hist_t hist, input row_t row);
    if (HASH_PC) return hist ^ hist_t'(row);
    return hist;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] lht_valid_q [INSTR_PER_FETCH];
  hist_t           lht_hist_q  [INSTR_PER_FETCH][ROWS];
  ctr_t            pht_q       [INSTR_PER_FETCH][PHT_DEPTH];

  flush_state_e state_q, state_d;
  cnt_t         cnt_q, cnt_d;

  // The stage keeps the decoded row/slot rather than the whole PC; that is
  // all the read-modify-write needs.
  logic  stg_valid_q, stg_valid_d;
  row_t  stg_row_q,   stg_row_d;
  slot_t stg_slot_q,  stg_slot_d;
  logic  stg_taken_q, stg_taken_d;

  logic sweep_en;
  logic upd_accept;
  logic wr_en;

  assign sweep_en     = (state_q == ST_FLUSH);
  assign flush_busy_o = sweep_en;

  // Flush wins over a coincident update and also discards the staged one.
  assign upd_accept = bp.bht_update.valid && !sweep_en && !flush_bp_i &&
                      !(DEBUG_EN && debug_mode_i);
  assign wr_en      = stg_valid_q && !sweep_en && !flush_bp_i;

  // ---------------------------------------------------------------------------
  // Prediction
  // ---------------------------------------------------------------------------
  row_t f_row;
  assign f_row = pc_row(bp.vpc);

  always_comb begin
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      bp.bht_prediction[s].valid = lht_valid_q[s][f_row] && !sweep_en;
      bp.bht_prediction[s].taken = lht_valid_q[s][f_row] && !sweep_en &&
        pht_q[s][pht_idx(lht_hist_q[s][f_row], f_row)][CTR_BITS-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Update stage: reads the tables as written by the previous edge, so
  // back-to-back updates to one entry chain correctly.
  // ---------------------------------------------------------------------------
  hist_t cur_hist, new_hist;
  ctr_t  cur_ctr,  new_ctr;
  hist_t cur_idx;

  assign cur_hist = lht_hist_q[stg_slot_q][stg_row_q];
  assign cur_idx  = pht_idx(cur_hist, stg_row_q);
  assign cur_ctr  = pht_q[stg_slot_q][cur_idx];
  // Truncating {hist, taken} drops the oldest bit; also covers HIST_BITS=1.
  assign new_hist = hist_t'({cur_hist, stg_taken_q});

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_i   (cur_ctr),
    .taken_i (stg_taken_q),
    .ctr_o   (new_ctr)
  );

  always_comb begin
    stg_valid_d = upd_accept;
    stg_row_d   = stg_row_q;
    stg_slot_d  = stg_slot_q;
    stg_taken_d = stg_taken_q;
    if (upd_accept) begin
      stg_row_d   = pc_row(bp.bht_update.pc);
      stg_slot_d  = pc_slot(bp.bht_update.pc);
      stg_taken_d = bp.bht_update.taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush sweep FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_bp_i) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_bp_i) begin
          cnt_d = '0;
        end else if (cnt_q == SWEEP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_row_q   <= '0;
      stg_slot_q  <= '0;
      stg_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_valid_q <= stg_valid_d;
      stg_row_q   <= stg_row_d;
      stg_slot_q  <= stg_slot_d;
      stg_taken_q <= stg_taken_d;
    end
  end

  // NOTE: the tables are flop arrays with an async reset of every entry;
  // predictions must be clean right out of reset, without waiting for a sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        lht_valid_q[s] <= '0;
        for (int r = 0; r < ROWS; r++)      lht_hist_q[s][r] <= '0;
        for (int p = 0; p < PHT_DEPTH; p++) pht_q[s][p]      <= CTR_INIT;
      end
    end else if (sweep_en) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        if (32'(cnt_q) < ROWS) begin
          lht_valid_q[s][row_t'(cnt_q)] <= 1'b0;
          lht_hist_q[s][row_t'(cnt_q)]  <= '0;
        end
        if (32'(cnt_q) < PHT_DEPTH) pht_q[s][hist_t'(cnt_q)] <= CTR_INIT;
      end
    end else if (wr_en) begin
      lht_valid_q[stg_slot_q][stg_row_q] <= 1'b1;
      lht_hist_q[stg_slot_q][stg_row_q]  <= new_hist;
      pht_q[stg_slot_q][cur_idx]         <= new_ctr;
    end
  end

endmodule

// File: tb/tb_lhp_bht.sv
// -----------------------------------------------------------------------------
// tb_lhp_bht
// Directed bench for lhp_bht with NR_ENTRIES=64, INSTR_PER_FETCH=2, RVC=1,
// HIST_BITS=4, CTR_BITS=2 (row=pc[6:2], slot=pc[1], sweep length 32).
// -----------------------------------------------------------------------------
module tb_lhp_bht;
  import lhp_bht_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_bp;
  logic debug_mode;
  logic flush_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lhp_bht_if #(.INSTR_PER_FETCH(2)) bp_if ();

  lhp_bht #(
    .NR_ENTRIES      (64),
    .INSTR_PER_FETCH (2),
    .RVC             (1'b1),
    .DEBUG_EN        (1'b1),
    .HIST_BITS       (4),
    .CTR_BITS        (2),
    .HASH_PC         (1'b0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_bp_i   (flush_bp),
    .debug_mode_i (debug_mode),
    .bp           (bp_if),
    .flush_busy_o (flush_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Presents an update for exactly one cycle; back-to-back calls keep valid
  // high without a gap.
  task automatic drive_upd(input logic [31:0] pc, input logic tk);
    bp_if.bht_update = '{valid: 1'b1, pc: pc, taken: tk};
    next_cycle();
    bp_if.bht_update.valid = 1'b0;
  endtask

  // {slot1.valid, slot1.taken, slot0.valid, slot0.taken}
  function automatic logic [31:0] preds();
    return {28'd0, bp_if.bht_prediction[1].valid, bp_if.bht_prediction[1].taken,
            bp_if.bht_prediction[0].valid, bp_if.bht_prediction[0].taken};
  endfunction

  function automatic logic [31:0] slot(input int s);
    return {30'd0, bp_if.bht_prediction[s].valid, bp_if.bht_prediction[s].taken};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    rst_n      = 1'b0;
    flush_bp   = 1'b0;
    debug_mode = 1'b0;
    bp_if.vpc  = 32'h104;
    bp_if.bht_update = '{valid: 1'b0, pc: 32'h0, taken: 1'b0};
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Reset state
    sample();
    check("rst_pred", preds(), 32'h0);
    check("rst_busy", {31'd0, flush_busy}, 32'd0);

    // Single taken update to 0x104 (row 1, slot 0): PHT0[0] 10->11, hist 0001,
    // prediction reads PHT0[1]=10 -> taken.
    next_cycle();
    drive_upd(32'h104, 1'b1);
    sample();
    check("upd_n1_old", slot(0), 32'd0);
    next_cycle();
    sample();
    check("upd_n2_slot0", slot(0), 32'd3);
    check("upd_n2_slot1", slot(1), 32'd0);

    // Four not-taken updates back-to-back to 0x108 (row 2, slot 0, hist 0000).
    // PHT0[0]: 11->10->01->00->00 (saturates at zero).
    next_cycle();
    bp_if.vpc = 32'h108;
    drive_upd(32'h108, 1'b0);
    drive_upd(32'h108, 1'b0);
    sample();
    check("nt_after1", slot(0), 32'd3);
    drive_upd(32'h108, 1'b0);
    sample();
    check("nt_after2", slot(0), 32'd2);
    drive_upd(32'h108, 1'b0);
    sample();
    check("nt_after3", slot(0), 32'd2);
    next_cycle();
    sample();
    check("nt_after4_sat0", slot(0), 32'd2);

    // Taken updates to 0x10E (row 3, slot 1); slot 0 of row 3 stays empty.
    next_cycle();
    bp_if.vpc = 32'h10E;
    drive_upd(32'h10E, 1'b1);
    next_cycle();
    sample();
    check("slot1_first", slot(1), 32'd3);
    check("slot1_row_slot0", slot(0), 32'd0);
    // Five more: indices 1,3,7,15,15 -> PHT1[15] reaches 11 and stays there.
    next_cycle();
    for (int i = 0; i < 5; i++) drive_upd(32'h10E, 1'b1);
    next_cycle();
    sample();
    check("slot1_sat_max", slot(1), 32'd3);

    // Debug mode blocks updates to fresh row 4 (pc 0x110).
    next_cycle();
    bp_if.vpc  = 32'h110;
    debug_mode = 1'b1;
    drive_upd(32'h110, 1'b1);
    next_cycle();
    sample();
    check("debug_blocked", slot(0), 32'd0);
    // Same update without debug: PHT0[0] 00->01, hist 0001, PHT0[1]=10.
    next_cycle();
    debug_mode = 1'b0;
    drive_upd(32'h110, 1'b1);
    next_cycle();
    sample();
    check("debug_off_upd", slot(0), 32'd3);

    // Flush with a coincident update, restart in the 10th busy cycle, and
    // updates offered during the first 20 busy cycles.
    next_cycle();
    bp_if.vpc = 32'h104;
    flush_bp  = 1'b1;
    bp_if.bht_update = '{valid: 1'b1, pc: 32'h110, taken: 1'b1};
    next_cycle();
    flush_bp = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      sample();
      if (!flush_busy) break;
      busy_cnt++;
      if (busy_cnt == 1) check("sweep_pred_gated", preds(), 32'h0);
      flush_bp = (busy_cnt == 10);
      bp_if.bht_update = '{valid: (busy_cnt < 20), pc: 32'h110, taken: 1'b1};
      next_cycle();
    end
    flush_bp = 1'b0;
    bp_if.bht_update.valid = 1'b0;
    check("flush_busy_len", busy_cnt, 32'd42);
    // First idle cycle: every row reads empty.
    bp_if.vpc = 32'h104;
    #1 check("post_flush_104", preds(), 32'h0);
    bp_if.vpc = 32'h10E;
    #1 check("post_flush_10e", preds(), 32'h0);
    bp_if.vpc = 32'h110;
    #1 check("post_flush_110", preds(), 32'h0);
    // Update accepted in the first idle cycle: NT on 0x10E with hist and PHT
    // back to reset values -> PHT1[0] 10->01, hist 0000 -> not taken.
    bp_if.vpc = 32'h10E;
    drive_upd(32'h10E, 1'b0);
    sample();
    check("post_flush_n1", slot(1), 32'd0);
    next_cycle();
    sample();
    check("post_flush_upd", slot(1), 32'd2);

    // Async reset in the second sweep cycle, before row 3 has been cleared.
    next_cycle();
    flush_bp = 1'b1;
    next_cycle();
    flush_bp = 1'b0;
    next_cycle();
    sample();
    check("rst_mid_busy_before", {31'd0, flush_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_mid_pred", preds(), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    sample();
    check("rst_after_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_after_pred", preds(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
